// File: rtl/irq_defs.sv
// Shared definitions for the interrupt sequencer.
//
// Contents:
//   state_t          - sequencer FSM state encoding (also exposed as a debug output)
//   BAK_*            - register-bank backup codes driven on o_irq_bak
//   VEC_BASE_DEFAULT - default byte address of the source-0 handler
//   IDX_W            - width of a source index (covers up to 8 sources)
//   vec_addr()       - handler address for a given source index
package irq_defs;

    localparam int IDX_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SAVE    = 3'd1,
        ST_VECTOR  = 3'd2,
        ST_HANDLER = 3'd3,
        ST_RETURN  = 3'd4
    } state_t;

    // 00: bank loads r0/r1 with the handler arguments
    // 10: bank saves sp and the sequential next PC
    // 11: bank saves sp and the PC of a register-file write already in flight
    localparam logic [1:0] BAK_LOAD      = 2'b00;
    localparam logic [1:0] BAK_SAVE_NEXT = 2'b10;
    localparam logic [1:0] BAK_SAVE_INFL = 2'b11;

    localparam logic [31:0] VEC_BASE_DEFAULT = 32'h0000_0018;

    // Handlers are one word apart: base + 4 * index.
    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [IDX_W-1:0] idx);
        return base + {27'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest-index asserted request wins.
//
// Ports:
//   req_i   [N-1:0]      request vector
//   idx_o   [IDX_W-1:0]  index of the winning request (0 when none)
//   valid_o              at least one request asserted
module irq_prio_enc
    import irq_defs::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Scan from the top down so the last (lowest) hit overwrites the rest.
    always_comb begin
        idx_o   = '0;
        valid_o = |req_i;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt entry/exit sequencer for a pipelined core with a banked
// interrupt register set.
//
// Rising edges on i_irq latch pending bits. When something is pending and
// the global mask is clear, the sequencer walks IDLE -> SAVE -> VECTOR ->
// HANDLER, redirecting the PC to VEC_BASE + 4*index. An eret seen in
// HANDLER captures the banked LR and RETURN redirects the PC back to it.
// Nothing advances while en is low.
//
// Parameters:
//   N_SRC     number of interrupt lines (2..8)
//   VEC_BASE  byte address of the source-0 handler
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en                  pipeline advance; all state holds when low
//   i_irq [N_SRC-1:0]   interrupt lines, rising-edge sensitive
//   i_irq_mask          blocks acceptance from IDLE only
//   i_eret              exception return in EX (honoured in HANDLER only)
//   i_lr [31:0]         banked r14 read value
//   i_pc_en             register-file PC write in flight
//   o_int_mode          selects the interrupt register bank
//   o_irq_bak [1:0]     bank backup code (see irq_defs)
//   o_irq_r0/o_irq_r1   handler arguments: source index, pending snapshot
//   o_pc_en/o_pc_reg    PC redirect request and target
//   o_flush             flush younger pipeline stages
//   o_dbg_state [2:0]   current FSM state (state_t encoding)
//
// Build option:
//   IRQ_SYNC_EN  when defined, i_irq passes through a two-flop synchronizer
//                (gated by en) before edge detection.
module irq_sequencer
    import irq_defs::*;
#(
    parameter int          N_SRC    = 4,
    parameter logic [31:0] VEC_BASE = VEC_BASE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_SRC-1:0] i_irq,
    input  logic             i_irq_mask,
    input  logic             i_eret,
    input  logic [31:0]      i_lr,
    input  logic             i_pc_en,
    output logic             o_int_mode,
    output logic [1:0]       o_irq_bak,
    output logic [31:0]      o_irq_r0,
    output logic [31:0]      o_irq_r1,
    output logic             o_pc_en,
    output logic [31:0]      o_pc_reg,
    output logic             o_flush,
    output logic [2:0]       o_dbg_state
);

    state_t           state_q, state_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] snap_q, snap_d;
    logic [N_SRC-1:0] irq_prev_q;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      lr_q, lr_d;

    logic [N_SRC-1:0] irq_s;
    logic [N_SRC-1:0] irq_rise;
    logic [N_SRC-1:0] clr_mask;
    logic [IDX_W-1:0] win_idx;
    logic             win_valid;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
`ifdef IRQ_SYNC_EN
    logic [N_SRC-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else if (en) begin
            sync1_q <= i_irq;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = i_irq;
`endif

    assign irq_rise = irq_s & ~irq_prev_q;

    // A fresh edge wins over a VECTOR clear of the same bit.
    assign pending_d = (pending_q & ~clr_mask) | irq_rise;

    irq_prio_enc #(
        .N (N_SRC)
    ) u_prio (
        .req_i   (pending_q),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            snap_q     <= '0;
            irq_prev_q <= '0;
            idx_q      <= '0;
            lr_q       <= '0;
        end else if (en) begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            snap_q     <= snap_d;
            irq_prev_q <= irq_s;
            idx_q      <= idx_d;
            lr_q       <= lr_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        snap_d     = snap_q;
        lr_d       = lr_q;
        clr_mask   = '0;
        o_int_mode = 1'b0;
        o_irq_bak  = BAK_LOAD;
        // Outside IDLE the arguments are the values captured at acceptance.
        o_irq_r0   = {{(32-IDX_W){1'b0}}, idx_q};
        o_irq_r1   = {{(32-N_SRC){1'b0}}, snap_q};
        o_pc_en    = 1'b0;
        o_pc_reg   = '0;
        o_flush    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                o_irq_r0 = {{(32-IDX_W){1'b0}}, win_idx};
                o_irq_r1 = {{(32-N_SRC){1'b0}}, pending_q};
                if (win_valid && !i_irq_mask) begin
                    state_d = ST_SAVE;
                    idx_d   = win_idx;
                    snap_d  = pending_q;
                end
            end
            ST_SAVE: begin
                // A redirect already in flight is the address to come back to.
                o_irq_bak = i_pc_en ? BAK_SAVE_INFL : BAK_SAVE_NEXT;
                state_d   = ST_VECTOR;
            end
            ST_VECTOR: begin
                o_int_mode = 1'b1;
                o_pc_en    = 1'b1;
                o_pc_reg   = vec_addr(VEC_BASE, idx_q);
                o_flush    = 1'b1;
                clr_mask   = {{(N_SRC-1){1'b0}}, 1'b1} << idx_q;
                state_d    = ST_HANDLER;
            end
            ST_HANDLER: begin
                o_int_mode = 1'b1;
                if (i_eret) begin
                    lr_d    = i_lr;
                    state_d = ST_RETURN;
                end
            end
            ST_RETURN: begin
                o_pc_en  = 1'b1;
                o_pc_reg = lr_q;
                o_flush  = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: a table of per-cycle input/expected
// output records plus hand-written reset-in-handler and entry-latency checks.
module tb_irq_sequencer;
  import irq_defs::*;

`ifdef IRQ_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  localparam int W = 104;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  i_irq;
  logic        i_irq_mask;
  logic        i_eret;
  logic [31:0] i_lr;
  logic        i_pc_en;
  logic        o_int_mode;
  logic [1:0]  o_irq_bak;
  logic [31:0] o_irq_r0;
  logic [31:0] o_irq_r1;
  logic        o_pc_en;
  logic [31:0] o_pc_reg;
  logic        o_flush;
  logic [2:0]  o_dbg_state;

  typedef struct {
    logic        en;
    logic [3:0]  irq;
    logic        mask;
    logic        eret;
    logic [31:0] lr;
    logic        pcen;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[$];
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  irq_sequencer #(.N_SRC(4), .VEC_BASE(32'h0000_0018)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .i_irq(i_irq), .i_irq_mask(i_irq_mask),
    .i_eret(i_eret), .i_lr(i_lr), .i_pc_en(i_pc_en), .o_int_mode(o_int_mode),
    .o_irq_bak(o_irq_bak), .o_irq_r0(o_irq_r0), .o_irq_r1(o_irq_r1),
    .o_pc_en(o_pc_en), .o_pc_reg(o_pc_reg), .o_flush(o_flush),
    .o_dbg_state(o_dbg_state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pack(input logic [2:0] st, input logic im,
      input logic [1:0] bak, input logic [31:0] r0, input logic [31:0] r1,
      input logic pce, input logic [31:0] pcr, input logic fl);
    return {st, im, bak, r0, r1, pce, pcr, fl};
  endfunction

  function automatic logic [W-1:0] actual();
    return {o_dbg_state, o_int_mode, o_irq_bak, o_irq_r0, o_irq_r1, o_pc_en, o_pc_reg, o_flush};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got st=%0d im=%0b bak=%b r0=%h r1=%h pce=%0b pc=%h fl=%0b, want st=%0d im=%0b bak=%b r0=%h r1=%h pce=%0b pc=%h fl=%0b",
        name, act[103:101], act[100], act[99:98], act[97:66], act[65:34], act[33], act[32:1], act[0],
        exp[103:101], exp[100], exp[99:98], exp[97:66], exp[65:34], exp[33], exp[32:1], exp[0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic add(input logic e, input logic [3:0] irq, input logic m, input logic er,
      input logic [31:0] lr, input logic pc, input logic [2:0] st, input logic im,
      input logic [1:0] bak, input logic [31:0] r0, input logic [31:0] r1,
      input logic pce, input logic [31:0] pcr, input logic fl);
    vec_t v;
    v.en = e; v.irq = irq; v.mask = m; v.eret = er; v.lr = lr; v.pcen = pc;
    v.exp = pack(st, im, bak, r0, r1, pce, pcr, fl);
    tbl.push_back(v);
  endtask

  task automatic idle_inputs();
    en = 1'b1; i_irq = '0; i_irq_mask = 1'b0; i_eret = 1'b0; i_lr = '0; i_pc_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("reset_outputs", actual(), pack(3'(ST_IDLE), 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] st, input string name);
    int k;
    k = 0;
    while (o_dbg_state != st && k < 20) begin
      @(posedge clk); #1; k++;
    end
    if (o_dbg_state != st) begin
      n_checks++; n_errors++;
      $display("FAIL %s: timeout waiting for state %0d, got %0d", name, st, o_dbg_state);
    end
  endtask

  localparam logic [2:0] I = 3'(ST_IDLE);
  localparam logic [2:0] S = 3'(ST_SAVE);
  localparam logic [2:0] V = 3'(ST_VECTOR);
  localparam logic [2:0] H = 3'(ST_HANDLER);
  localparam logic [2:0] R = 3'(ST_RETURN);

  initial begin
    int cnt;
    rst_n = 1'b0;
    idle_inputs();
    do_reset();

`ifndef IRQ_SYNC_EN
    // en irq mask eret lr pcen | st im bak r0 r1 pce pc fl
    // single source 2, bak=10
    add(1, 4'b0000, 0, 0, 32'h0,   0, I, 0, 2'b00, 32'd0, 32'h0, 0, 32'h0,   0);
    add(1, 4'b0100, 0, 0, 32'h0,   0, I, 0, 2'b00, 32'd0, 32'h0, 0, 32'h0,   0);
    add(1, 4'b0100, 0, 0, 32'h0,   0, I, 0, 2'b00, 32'd2, 32'h4, 0, 32'h0,   0);
    add(1, 4'b0100, 0, 0, 32'h0,   0, S, 0, 2'b10, 32'd2, 32'h4, 0, 32'h0,   0);
    add(1, 4'b0100, 0, 0, 32'h0,   0, V, 1, 2'b00, 32'd2, 32'h4, 1, 32'h20,  1);
    add(1, 4'b0000, 0, 0, 32'h0,   0, H, 1, 2'b00, 32'd2, 32'h4, 0, 32'h0,   0);
    add(1, 4'b0000, 0, 1, 32'h40,  0, H, 1, 2'b00, 32'd2, 32'h4, 0, 32'h0,   0);
    add(1, 4'b0000, 0, 0, 32'h0,   0, R, 0, 2'b00, 32'd2, 32'h4, 1, 32'h40,  1);
    add(1, 4'b0000, 0, 0, 32'h0,   0, I, 0, 2'b00, 32'd0, 32'h0, 0, 32'h0,   0);
    // sources 3 and 1 together, bak=11, return then re-entry on source 3
    add(1, 4'b1010, 0, 0, 32'h0,   0, I, 0, 2'b00, 32'd0, 32'h0, 0, 32'h0,   0);
    add(1, 4'b1010, 0, 0, 32'h0,   1, I, 0, 2'b00, 32'd1, 32'hA, 0, 32'h0,   0);
    add(1, 4'b1010, 0, 0, 32'h0,   1, S, 0, 2'b11, 32'd1, 32'hA, 0, 32'h0,   0);
    add(1, 4'b1010, 0, 0, 32'h0,   0, V, 1, 2'b00, 32'd1, 32'hA, 1, 32'h1C,  1);
    add(1, 4'b1010, 0, 1, 32'h100, 0, H, 1, 2'b00, 32'd1, 32'hA, 0, 32'h0,   0);
    add(1, 4'b1010, 0, 0, 32'h0,   0, R, 0, 2'b00, 32'd1, 32'hA, 1, 32'h100, 1);
    add(1, 4'b1010, 0, 0, 32'h0,   0, I, 0, 2'b00, 32'd3, 32'h8, 0, 32'h0,   0);
    add(1, 4'b1010, 0, 0, 32'h0,   0, S, 0, 2'b10, 32'd3, 32'h8, 0, 32'h0,   0);
    add(1, 4'b1010, 0, 0, 32'h0,   0, V, 1, 2'b00, 32'd3, 32'h8, 1, 32'h24,  1);
    add(1, 4'b1010, 0, 1, 32'h200, 0, H, 1, 2'b00, 32'd3, 32'h8, 0, 32'h0,   0);
    add(1, 4'b1010, 0, 0, 32'h0,   0, R, 0, 2'b00, 32'd3, 32'h8, 1, 32'h200, 1);
    // eret outside HANDLER is ignored
    add(1, 4'b1010, 0, 1, 32'h999, 0, I, 0, 2'b00, 32'd0, 32'h0, 0, 32'h0,   0);
    // mask blocks entry; en=0 freezes VECTOR
    add(1, 4'b0000, 0, 0, 32'h0,   0, I, 0, 2'b00, 32'd0, 32'h0, 0, 32'h0,   0);
    add(1, 4'b0001, 1, 0, 32'h0,   0, I, 0, 2'b00, 32'd0, 32'h0, 0, 32'h0,   0);
    add(1, 4'b0001, 1, 0, 32'h0,   0, I, 0, 2'b00, 32'd0, 32'h1, 0, 32'h0,   0);
    add(1, 4'b0001, 1, 0, 32'h0,   0, I, 0, 2'b00, 32'd0, 32'h1, 0, 32'h0,   0);
    add(1, 4'b0001, 0, 0, 32'h0,   0, I, 0, 2'b00, 32'd0, 32'h1, 0, 32'h0,   0);
    add(1, 4'b0001, 1, 0, 32'h0,   0, S, 0, 2'b10, 32'd0, 32'h1, 0, 32'h0,   0);
    add(0, 4'b0001, 1, 0, 32'h0,   0, V, 1, 2'b00, 32'd0, 32'h1, 1, 32'h18,  1);
    add(0, 4'b0011, 1, 0, 32'h0,   0, V, 1, 2'b00, 32'd0, 32'h1, 1, 32'h18,  1);
    add(0, 4'b0001, 1, 0, 32'h0,   0, V, 1, 2'b00, 32'd0, 32'h1, 1, 32'h18,  1);
    add(1, 4'b0001, 1, 0, 32'h0,   0, V, 1, 2'b00, 32'd0, 32'h1, 1, 32'h18,  1);
    // new edge in HANDLER only sets pending; mask still ignored
    add(1, 4'b0011, 1, 0, 32'h0,   0, H, 1, 2'b00, 32'd0, 32'h1, 0, 32'h0,   0);
    add(1, 4'b0011, 1, 1, 32'h300, 0, H, 1, 2'b00, 32'd0, 32'h1, 0, 32'h0,   0);
    add(1, 4'b0011, 1, 0, 32'h0,   0, R, 0, 2'b00, 32'd0, 32'h1, 1, 32'h300, 1);
    add(1, 4'b0011, 1, 0, 32'h0,   0, I, 0, 2'b00, 32'd1, 32'h2, 0, 32'h0,   0);
    add(0, 4'b0011, 0, 0, 32'h0,   0, I, 0, 2'b00, 32'd1, 32'h2, 0, 32'h0,   0);

    foreach (tbl[n]) exp_q.push_back(tbl[n].exp);
    for (int n = 0; n < tbl.size(); n++) begin
      logic [W-1:0] e;
      @(negedge clk);
      en = tbl[n].en; i_irq = tbl[n].irq; i_irq_mask = tbl[n].mask;
      i_eret = tbl[n].eret; i_lr = tbl[n].lr; i_pc_en = tbl[n].pcen;
      #1;
      e = exp_q.pop_front();
      check($sformatf("vec%0d", n), actual(), e);
    end
`endif

    // reset pulsed while in HANDLER with another source pending
    do_reset();
    @(negedge clk);
    i_irq = 4'b0001;
    wait_state(H, "reach_handler");
    @(negedge clk);
    i_irq = 4'b0011;
    repeat (SYNC_LAT + 2) @(negedge clk);
    check("handler_before_reset", actual(), pack(H, 1'b1, 2'b00, 32'd0, 32'h1, 1'b0, 32'h0, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_in_handler", actual(), pack(I, 1'b0, 2'b00, 32'd0, 32'h0, 1'b0, 32'h0, 1'b0));
    i_irq = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no_return_after_reset", actual(), pack(I, 1'b0, 2'b00, 32'd0, 32'h0, 1'b0, 32'h0, 1'b0));

    // entry latency from an edge to SAVE
    @(negedge clk);
    i_irq = 4'b0001;
    cnt = 0;
    while (o_dbg_state != S && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    check_int("entry_latency", cnt, 2 + SYNC_LAT);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
